time_entry_ctrl: RTL

//  Keypad-side producer for the BCD time counter's load interface.
//  - Collects decimal key presses into a 4-digit HH:MM BCD buffer.
//  - Validates the buffer; on TIME/ALARM key, issues a 1-cycle load strobe with the digits.
//  - Sits between keypad decoder and time counter / alarm register.

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/time_valid_chk.sv | 32 +++
 rtl/time_entry_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the keypad time-entry path: key codes, BCD digit
// type, entry FSM states and the HH:MM range limits used by the validator.
package alarm_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Keypad codes above the decimal digits
    localparam bcd_digit_t KEY_ALARM = 4'd10;
    localparam bcd_digit_t KEY_TIME  = 4'd11;
    localparam bcd_digit_t KEY_CLEAR = 4'd12;

    // Largest legal values of the range-limited digits (23:59)
    localparam bcd_digit_t MAX_HR_MS  = 4'd2;
    localparam bcd_digit_t MAX_HR_LS  = 4'd3;
    localparam bcd_digit_t MAX_MIN_MS = 4'd5;
    localparam bcd_digit_t MAX_DIGIT  = 4'd9;

    // A complete entry has four digits
    localparam logic [2:0] FULL_COUNT = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } entry_state_t;

    function automatic logic is_digit(input bcd_digit_t k);
        return (k <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/time_valid_chk.sv
// Combinational HH:MM range check on four BCD digits. Accepts 00:00..23:59.
// Shared by the current-time and alarm-time load paths.
module time_valid_chk
    import alarm_pkg::*;
(
    input  logic [3:0] ms_hr,
    input  logic [3:0] ls_hr,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    output logic       valid
);

    logic hr_ok;
    logic min_ok;
    logic digits_ok;

    // Hours: 00-19 freely, 20-23 only with a small units digit
    always_comb begin
        hr_ok = (ms_hr < MAX_HR_MS) ||
                ((ms_hr == MAX_HR_MS) && (ls_hr <= MAX_HR_LS));
    end

    // Minutes tens limited to 5; every digit must also be decimal
    always_comb begin
        min_ok    = (ms_min <= MAX_MIN_MS);
        digits_ok = is_digit(ms_hr) && is_digit(ls_hr) &&
                    is_digit(ms_min) && is_digit(ls_min);
    end

    assign valid = hr_ok && min_ok && digits_ok;

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad-side producer for the time counter / alarm register load interface.
// Collects digits into an HH:MM BCD buffer and, on TIME or ALARM, issues a
// one-cycle load strobe (or an error strobe if the buffer is not a legal time).
// Optional feature macro: ENTRY_TIMEOUT_EN -- abandons an entry after
// TIMEOUT_SEC one_second ticks without a key press.
module time_entry_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       one_second,
    output logic [3:0] new_time_ms_hr,
    output logic [3:0] new_time_ls_hr,
    output logic [3:0] new_time_ms_min,
    output logic [3:0] new_time_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       entry_error
);

    entry_state_t state_reg, state_next;
    bcd_digit_t   ms_hr_reg, ms_hr_next;
    bcd_digit_t   ls_hr_reg, ls_hr_next;
    bcd_digit_t   ms_min_reg, ms_min_next;
    bcd_digit_t   ls_min_reg, ls_min_next;
    logic [2:0]   count_reg, count_next;
    logic         load_c_reg, load_c_next;
    logic         load_a_reg, load_a_next;
    logic         error_reg, error_next;
    logic         buf_valid;
    logic         load_ok;

    time_valid_chk u_valid_chk (
        .ms_hr  (ms_hr_reg),
        .ls_hr  (ls_hr_reg),
        .ms_min (ms_min_reg),
        .ls_min (ls_min_reg),
        .valid  (buf_valid)
    );

    // A load is only accepted with a full four-digit buffer holding a legal time
    assign load_ok = buf_valid && (count_reg == FULL_COUNT);

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_SEC);
    logic [7:0] timer_reg, timer_next;
`else
    // Without the timeout the tick input and limit have no function
    logic       unused_one_second;
    logic [7:0] unused_timeout;
    assign unused_one_second = one_second;
    assign unused_timeout    = 8'(TIMEOUT_SEC);
`endif

    // Next-state and next-output logic for the entry FSM
    always_comb begin
        state_next  = state_reg;
        ms_hr_next  = ms_hr_reg;
        ls_hr_next  = ls_hr_reg;
        ms_min_next = ms_min_reg;
        ls_min_next = ls_min_reg;
        count_next  = count_reg;
        load_c_next = 1'b0;
        load_a_next = 1'b0;
        error_next  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        timer_next  = timer_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // Only a digit starts an entry; command keys are ignored here
                if (key_valid && is_digit(key)) begin
                    ms_hr_next  = '0;
                    ls_hr_next  = '0;
                    ms_min_next = '0;
                    ls_min_next = key;
                    count_next  = 3'd1;
                    state_next  = ST_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
                    timer_next  = '0;
`endif
                end
            end
            ST_ENTRY: begin
                if (key_valid) begin
`ifdef ENTRY_TIMEOUT_EN
                    // Any key, even an ignored code, restarts the inactivity timer
                    timer_next = '0;
`endif
                    if (is_digit(key)) begin
                        // Shift left; the oldest digit falls off once full
                        ms_hr_next  = ls_hr_reg;
                        ls_hr_next  = ms_min_reg;
                        ms_min_next = ls_min_reg;
                        ls_min_next = key;
                        if (count_reg != FULL_COUNT) begin
                            count_next = count_reg + 3'd1;
                        end
                    end else if ((key == KEY_TIME) || (key == KEY_ALARM)) begin
                        // Buffer is held so the digits are stable under the strobe
                        if (!load_ok) begin
                            error_next = 1'b1;
                        end else if (key == KEY_TIME) begin
                            load_c_next = 1'b1;
                        end else begin
                            load_a_next = 1'b1;
                        end
                        count_next = '0;
                        state_next = ST_IDLE;
                    end else if (key == KEY_CLEAR) begin
                        ms_hr_next  = '0;
                        ls_hr_next  = '0;
                        ms_min_next = '0;
                        ls_min_next = '0;
                        count_next  = '0;
                        state_next  = ST_IDLE;
                    end
                end
`ifdef ENTRY_TIMEOUT_EN
                else if (one_second) begin
                    if ((timer_reg + 8'd1) >= TIMEOUT_LIM) begin
                        ms_hr_next  = '0;
                        ls_hr_next  = '0;
                        ms_min_next = '0;
                        ls_min_next = '0;
                        count_next  = '0;
                        timer_next  = '0;
                        state_next  = ST_IDLE;
                    end else begin
                        timer_next = timer_reg + 8'd1;
                    end
                end
`endif
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, buffer and strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            ms_hr_reg  <= '0;
            ls_hr_reg  <= '0;
            ms_min_reg <= '0;
            ls_min_reg <= '0;
            count_reg  <= '0;
            load_c_reg <= 1'b0;
            load_a_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ms_hr_reg  <= ms_hr_next;
            ls_hr_reg  <= ls_hr_next;
            ms_min_reg <= ms_min_next;
            ls_min_reg <= ls_min_next;
            count_reg  <= count_next;
            load_c_reg <= load_c_next;
            load_a_reg <= load_a_next;
            error_reg  <= error_next;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    // Inactivity timer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`endif

    assign new_time_ms_hr  = ms_hr_reg;
    assign new_time_ls_hr  = ls_hr_reg;
    assign new_time_ms_min = ms_min_reg;
    assign new_time_ls_min = ls_min_reg;
    assign load_new_c      = load_c_reg;
    assign load_new_a      = load_a_reg;
    assign entry_error     = error_reg;
    assign show_new_time   = (state_reg == ST_ENTRY);

endmodule
